// File: rtl/payout_dispenser_pkg.sv
// payout_dispenser_pkg
//   Shared definitions for the payout dispenser slice: controller state
//   enum, default parameter values and the next-request selection helper.
package payout_dispenser_pkg;

  localparam int unsigned PAY_CNT_W_DEF       = 3;
  localparam int unsigned PAY_GAP_CYCLES_DEF  = 1;
  localparam int unsigned PAY_TIMEOUT_CYC_DEF = 16;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    VOUCHER = 3'd1,
    NICKEL  = 3'd2,
    GAP     = 3'd3,
    FAULT   = 3'd4
  } pay_state_e;

  // Vouchers always win over nickels when both are owed.
  function automatic pay_state_e pick_next(input logic voucher_owed,
                                           input logic nickel_owed);
    if (voucher_owed)     return VOUCHER;
    else if (nickel_owed) return NICKEL;
    else                  return IDLE;
  endfunction

endpackage

// File: rtl/payout_dispenser_if.sv
// payout_dispenser_if
//   Credit, dispense handshake and status signals of the payout dispenser.
//   slave  : the dispenser (takes credits and acks, drives reqs/status)
//   master : upstream coin counter plus dispense mechanism
//   Signals:
//     credit_valid, dollar, nickel   credit strobe and its owed items
//     voucher_req/ack, nickel_req/ack dispense handshakes
//     voucher_pend, nickel_pend       owed-and-not-acked counts (CNT_W)
//     overflow, busy, fault           status
interface payout_dispenser_if
  import payout_dispenser_pkg::*;
#(
  parameter int unsigned CNT_W = PAY_CNT_W_DEF
) ();

  logic             credit_valid;
  logic             dollar;
  logic             nickel;
  logic             voucher_req;
  logic             voucher_ack;
  logic             nickel_req;
  logic             nickel_ack;
  logic [CNT_W-1:0] voucher_pend;
  logic [CNT_W-1:0] nickel_pend;
  logic             overflow;
  logic             busy;
  logic             fault;

  modport slave (
    input  credit_valid, dollar, nickel, voucher_ack, nickel_ack,
    output voucher_req, nickel_req, voucher_pend, nickel_pend,
           overflow, busy, fault
  );

  modport master (
    output credit_valid, dollar, nickel, voucher_ack, nickel_ack,
    input  voucher_req, nickel_req, voucher_pend, nickel_pend,
           overflow, busy, fault
  );

endinterface

// File: rtl/sat_updown_cnt.sv
// sat_updown_cnt
//   Saturating up/down counter for owed payout items.
//   Ports:
//     clk, reset : clock, synchronous active-high reset
//     inc, dec   : count up / down this edge (both -> unchanged)
//     count      : current value
//     sat_hit    : inc requested at full scale without a dec (item lost)
module sat_updown_cnt #(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         sat_hit
);

  assign sat_hit = inc && !dec && (count == '1);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (inc && !dec && (count != '1)) begin
      count <= count + 1'b1;
    end else if (dec && !inc && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/payout_dispenser.sv
// payout_dispenser
//   Accumulates dollar-voucher and nickel credits from the coin counter and
//   dispenses them one at a time through req/ack handshakes, vouchers first,
//   with GAP_CYCLES idle cycles between dispenses.
//   Ports:
//     clk   : rising-edge clock
//     reset : synchronous active-high reset
//     bus   : payout_dispenser_if.slave (credits, handshakes, status)
//   Build option:
//     PAYOUT_TIMEOUT_EN : when defined, a request unanswered for TIMEOUT_CYC
//                         cycles drops, sets sticky fault and parks the
//                         controller in FAULT until reset. When undefined,
//                         requests wait forever and fault is tied low.
module payout_dispenser
  import payout_dispenser_pkg::*;
#(
  parameter int unsigned CNT_W       = PAY_CNT_W_DEF,
  parameter int unsigned GAP_CYCLES  = PAY_GAP_CYCLES_DEF,
  parameter int unsigned TIMEOUT_CYC = PAY_TIMEOUT_CYC_DEF
) (
  input  logic                clk,
  input  logic                reset,
  payout_dispenser_if.slave   bus
);

  pay_state_e       state;
  pay_state_e       state_nxt;
  logic [3:0]       gap_cnt;
  logic [3:0]       gap_cnt_nxt;

  logic             v_inc, v_dec, n_inc, n_dec;
  logic [CNT_W-1:0] v_cnt, n_cnt;
  logic             v_sat, n_sat;

  logic             voucher_req_q;
  logic             nickel_req_q;
  logic             overflow_q;
  logic             to_expire;

  // Acks only count while the matching request is being driven.
  assign v_inc = bus.credit_valid && bus.dollar;
  assign n_inc = bus.credit_valid && bus.nickel;
  assign v_dec = (state == VOUCHER) && bus.voucher_ack;
  assign n_dec = (state == NICKEL)  && bus.nickel_ack;

  sat_updown_cnt #(.W(CNT_W)) u_voucher_cnt (
    .clk     (clk),
    .reset   (reset),
    .inc     (v_inc),
    .dec     (v_dec),
    .count   (v_cnt),
    .sat_hit (v_sat)
  );

  sat_updown_cnt #(.W(CNT_W)) u_nickel_cnt (
    .clk     (clk),
    .reset   (reset),
    .inc     (n_inc),
    .dec     (n_dec),
    .count   (n_cnt),
    .sat_hit (n_sat)
  );

`ifdef PAYOUT_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);

  logic [TO_W-1:0] to_cnt;
  logic            in_req;
  logic            ack_cur;
  logic            fault_q;

  assign in_req  = (state == VOUCHER) || (state == NICKEL);
  assign ack_cur = v_dec || n_dec;
  // An ack on the last allowed cycle still wins over the timeout.
  assign to_expire = in_req && !ack_cur && (to_cnt == TO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      to_cnt  <= '0;
      fault_q <= 1'b0;
    end else begin
      to_cnt  <= (in_req && !ack_cur && !to_expire) ? to_cnt + 1'b1 : '0;
      fault_q <= fault_q || to_expire;
    end
  end

  assign bus.fault = fault_q;
`else
  assign to_expire = 1'b0;
  assign bus.fault = 1'b0;
`endif

  always_comb begin
    state_nxt   = state;
    gap_cnt_nxt = gap_cnt;
    case (state)
      IDLE: begin
        state_nxt = pick_next(v_cnt != '0, n_cnt != '0);
      end
      VOUCHER: begin
        if (bus.voucher_ack) begin
          state_nxt   = GAP;
          gap_cnt_nxt = '0;
        end else if (to_expire) begin
          state_nxt = FAULT;
        end
      end
      NICKEL: begin
        if (bus.nickel_ack) begin
          state_nxt   = GAP;
          gap_cnt_nxt = '0;
        end else if (to_expire) begin
          state_nxt = FAULT;
        end
      end
      GAP: begin
        if (gap_cnt == 4'(GAP_CYCLES - 1)) begin
          state_nxt = pick_next(v_cnt != '0, n_cnt != '0);
        end else begin
          gap_cnt_nxt = gap_cnt + 1'b1;
        end
      end
      FAULT: begin
        state_nxt = FAULT;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Requests are flopped from the next state so they rise with the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      gap_cnt       <= '0;
      voucher_req_q <= 1'b0;
      nickel_req_q  <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      state         <= state_nxt;
      gap_cnt       <= gap_cnt_nxt;
      voucher_req_q <= (state_nxt == VOUCHER);
      nickel_req_q  <= (state_nxt == NICKEL);
      overflow_q    <= overflow_q || v_sat || n_sat;
    end
  end

  assign bus.voucher_req  = voucher_req_q;
  assign bus.nickel_req   = nickel_req_q;
  assign bus.voucher_pend = v_cnt;
  assign bus.nickel_pend  = n_cnt;
  assign bus.overflow     = overflow_q;
  assign bus.busy         = (state != IDLE) || (v_cnt != '0) || (n_cnt != '0);

endmodule

// File: doc/payout_dispenser.md
PAYOUT_DISPENSER -- requirements
Module: payout_dispenser

Interface
REQ-001 Parameter CNT_W, default 3: width of each pending-payout counter.
REQ-002 Parameter GAP_CYCLES, default 1: idle cycles forced between consecutive dispense requests (range 1..15).
REQ-003 Parameter TIMEOUT_CYC, default 16: maximum cycles a request may wait for ack (used only under PAYOUT_TIMEOUT_EN).
REQ-004 Port clk, input, 1: single clock, rising-edge; one clock for the whole block.
REQ-005 Port reset, input, 1: synchronous, active-high reset.
REQ-006 Port credit_valid, input, 1: high when the upstream coin counter advanced this cycle (its enable).
REQ-007 Port dollar, input, 1: one dollar voucher owed, qualified by credit_valid.
REQ-008 Port nickel, input, 1: one nickel of change owed, qualified by credit_valid.
REQ-009 Port voucher_req, output, 1: dispense one voucher; held until acked.
REQ-010 Port voucher_ack, input, 1: mechanism has dispensed one voucher.
REQ-011 Port nickel_req, output, 1: dispense one nickel; held until acked.
REQ-012 Port nickel_ack, input, 1: mechanism has dispensed one nickel.
REQ-013 Port voucher_pend, output, CNT_W: vouchers owed and not yet acked.
REQ-014 Port nickel_pend, output, CNT_W: nickels owed and not yet acked.
REQ-015 Port overflow, output, 1: sticky; a credit was lost to saturation.
REQ-016 Port busy, output, 1: high when state is not IDLE or either pend counter is nonzero.
REQ-017 Port fault, output, 1: sticky; dispense timeout occurred.

Function
REQ-018 Credit: at a clk edge with credit_valid=1, dollar=1 increments voucher_pend and nickel=1 increments nickel_pend; both may increment in the same cycle.
REQ-019 Dollar/nickel with credit_valid=0 are ignored.
REQ-020 FSM states: IDLE, VOUCHER, NICKEL, GAP, FAULT; all outputs registered.
REQ-021 IDLE: voucher_pend!=0 -> VOUCHER; else nickel_pend!=0 -> NICKEL; else stay. Vouchers have priority over nickels.
REQ-022 Latency: a credit sampled at edge N gives pend=1 after N and req=1 after N+1, when starting from IDLE with empty counters.
REQ-023 VOUCHER: voucher_req=1; voucher_ack=1 at an edge -> voucher_req=0, voucher_pend decrements, go to GAP. NICKEL is the same using nickel_req/nickel_ack/nickel_pend.
REQ-024 Only one req is high at a time; an ack arriving while its req is low is ignored.
REQ-025 GAP: lasts exactly GAP_CYCLES cycles, then selects the next state using the REQ-021 priority rule.
REQ-026 Increment and decrement of the same counter at the same edge leave it unchanged.
REQ-027 Increment at max (2^CNT_W-1) with no decrement: the counter holds and overflow is set.
REQ-028 Decrement never occurs below 0, since a req is only issued when its pend is nonzero.
REQ-029 overflow and fault clear only on reset.

Reset
REQ-030 When reset=1 at an edge: state=IDLE, both reqs=0, both pends=0, overflow=0, fault=0, and gap/timeout counters=0; reset overrides all other inputs, including reset asserted mid-request.
REQ-031 Credits presented in the same cycle as reset are discarded.

Configuration
REQ-032 Macro PAYOUT_TIMEOUT_EN, when defined, enables the following: a counter runs while in VOUCHER or NICKEL; if no ack arrives within TIMEOUT_CYC cycles, the req drops, fault=1, and the FSM enters FAULT.
REQ-033 In FAULT, credits still accumulate into the counters (with saturation), but no reqs are issued until reset.
REQ-034 Without PAYOUT_TIMEOUT_EN: no timeout logic, reqs wait indefinitely for ack, fault is tied to 0, and FAULT is unreachable.

Structure
REQ-035 A shared package holds the state enum (IDLE, VOUCHER, NICKEL, GAP, FAULT) and the default constants for CNT_W, GAP_CYCLES and TIMEOUT_CYC.
REQ-036 The two identical counters use one sub-module, sat_updown_cnt, with inputs inc and dec and outputs count and sat_hit; it is instantiated twice.

Verification
REQ-037 Reset, then credit_valid=1 with dollar=1 for one cycle -> voucher_pend=1; voucher_req=1 one edge later; voucher_ack at the third req cycle -> voucher_req=0 and voucher_pend=0 after that edge.
REQ-038 dollar=1 and nickel=1 in the same credit -> voucher_req is served first, then exactly GAP_CYCLES=1 low cycle, then nickel_req=1; both pends reach 0 after their acks.
REQ-039 Eight dollar credits with no ack (CNT_W=3) -> voucher_pend=7, overflow=1, and overflow stays 1 after the queue drains.
REQ-040 voucher_pend=1, credit dollar at the same edge as voucher_ack -> voucher_pend stays 1; voucher_req returns after the gap.
REQ-041 With PAYOUT_TIMEOUT_EN, no ack for 16 cycles -> req=0 and fault=1; later credits raise pend but issue no req; reset clears everything.
REQ-042 reset=1 while nickel_req=1 and nickel_pend=3 -> after that edge nickel_req=0, pends=0, busy=0; a nickel_ack in the following cycle has no effect.
